// File: rtl/rtc_preset_ctrl_if.sv
// Host-side command bus of the RTC preset controller: command handshake,
// SET payload and the completion/rejection pulses.
interface rtc_preset_ctrl_if;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready;
    logic [1:0]  set_mode;
    logic [5:0]  set_sec;
    logic [5:0]  set_min;
    logic [4:0]  set_hour;
    logic [2:0]  set_dow;
    logic [4:0]  set_dom;
    logic [3:0]  set_month;
    logic [11:0] set_year;
    logic        done;
    logic        err;

    modport master (
        output cmd_valid, cmd, set_mode, set_sec, set_min, set_hour,
               set_dow, set_dom, set_month, set_year,
        input  cmd_ready, done, err
    );

    modport slave (
        input  cmd_valid, cmd, set_mode, set_sec, set_min, set_hour,
               set_dow, set_dom, set_month, set_year,
        output cmd_ready, done, err
    );
endinterface

// File: rtl/rtc_preset_ctrl.sv
// Command sequencer in front of the RTC counter. Turns START/STOP/SET
// commands into the enable/mode/preset waveforms the counter expects,
// rejecting SET payloads that are not a valid calendar date/time.
module rtc_preset_ctrl #(
    parameter int unsigned MIN_YEAR = 2000,
    parameter int unsigned MAX_YEAR = 2099
) (
    input  logic               clk_1Hz_i,
    input  logic               rstn_i,
    rtc_preset_ctrl_if.slave   host,
    output logic               cnt_enable_o,
    output logic               cnt_mode_o,
    output logic               en_preset_o,
    output logic [5:0]         init_sec_o,
    output logic [5:0]         init_min_o,
    output logic [4:0]         init_hour_o,
    output logic [1:0]         init_mode_o,
    output logic [2:0]         init_dow_o,
    output logic [4:0]         init_dom_o,
    output logic [3:0]         init_month_o,
    output logic [11:0]        init_year_o
);
    localparam logic [1:0]  CMD_START = 2'b01;
    localparam logic [1:0]  CMD_STOP  = 2'b10;
    localparam logic [1:0]  CMD_SET   = 2'b11;
    localparam logic [11:0] MIN_Y     = 12'(MIN_YEAR);
    localparam logic [11:0] MAX_Y     = 12'(MAX_YEAR);

    typedef enum logic [1:0] {IDLE, PRESET, SETTLE, DONE} state_t;

    state_t      state_q, state_d;
    logic        enable_q, enable_d;
    logic        mode_q, mode_d;
    logic        preset_q, preset_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [5:0]  sec_q, sec_d, min_q, min_d;
    logic [4:0]  hour_q, hour_d;
    logic [1:0]  imode_q, imode_d;
    logic [2:0]  dow_q, dow_d;
    logic [4:0]  dom_q, dom_d;
    logic [3:0]  month_q, month_d;
    logic [11:0] year_q, year_d;
    logic        set_ok;

    // Calendar/time validity of a SET payload; 2100 is the only century
    // year that can reach the leap test and it is not a leap year.
    function automatic logic set_is_valid(
        input logic [1:0]  mode,
        input logic [5:0]  sec,
        input logic [5:0]  min,
        input logic [4:0]  hour,
        input logic [2:0]  dow,
        input logic [4:0]  dom,
        input logic [3:0]  month,
        input logic [11:0] year
    );
        logic       leap;
        logic [4:0] maxday;
        logic       ok;
        leap = (year[1:0] == 2'b00) && (year != 12'd2100);
        case (month)
            4'd2:                    maxday = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: maxday = 5'd30;
            default:                 maxday = 5'd31;
        endcase
        ok = (sec <= 6'd59) && (min <= 6'd59);
        if (mode[0]) begin
            ok = ok && (hour >= 5'd1) && (hour <= 5'd12);
        end else begin
            ok = ok && (hour <= 5'd23) && !mode[1];
        end
        ok = ok && (dow != 3'd0);
        ok = ok && (month >= 4'd1) && (month <= 4'd12);
        ok = ok && (year >= MIN_Y) && (year <= MAX_Y);
        ok = ok && (dom >= 5'd1) && (dom <= maxday);
        return ok;
    endfunction

    assign set_ok = set_is_valid(host.set_mode, host.set_sec, host.set_min,
                                 host.set_hour, host.set_dow, host.set_dom,
                                 host.set_month, host.set_year);

    // Next-state and output decode; commands are only taken in IDLE.
    always_comb begin
        state_d  = state_q;
        enable_d = enable_q;
        mode_d   = mode_q;
        preset_d = 1'b0;
        err_d    = 1'b0;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        imode_d  = imode_q;
        dow_d    = dow_q;
        dom_d    = dom_q;
        month_d  = month_q;
        year_d   = year_q;
        case (state_q)
            IDLE: begin
                if (host.cmd_valid) begin
                    case (host.cmd)
                        CMD_START: begin
                            mode_d   = host.set_mode[0];
                            enable_d = 1'b1;
                            state_d  = DONE;
                        end
                        CMD_STOP: begin
                            enable_d = 1'b0;
                            state_d  = DONE;
                        end
                        CMD_SET: begin
                            if (set_ok) begin
                                sec_d    = host.set_sec;
                                min_d    = host.set_min;
                                hour_d   = host.set_hour;
                                imode_d  = host.set_mode;
                                dow_d    = host.set_dow;
                                dom_d    = host.set_dom;
                                month_d  = host.set_month;
                                year_d   = host.set_year;
                                mode_d   = host.set_mode[0];
                                enable_d = 1'b1;
                                preset_d = 1'b1;
                                state_d  = PRESET;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // The counter sees the preset rise on this edge; drop it now.
            PRESET: state_d = SETTLE;
            // The counter loads the init values on this edge.
            SETTLE: state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    // State and output registers; reset restores counter defaults.
    always_ff @(posedge clk_1Hz_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            mode_q   <= 1'b0;
            preset_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sec_q    <= 6'd0;
            min_q    <= 6'd0;
            hour_q   <= 5'd0;
            imode_q  <= 2'b00;
            dow_q    <= 3'd1;
            dom_q    <= 5'd1;
            month_q  <= 4'd1;
            year_q   <= 12'd2000;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            preset_q <= preset_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hour_q   <= hour_d;
            imode_q  <= imode_d;
            dow_q    <= dow_d;
            dom_q    <= dom_d;
            month_q  <= month_d;
            year_q   <= year_d;
        end
    end

    assign host.cmd_ready = (state_q == IDLE);
    assign host.done      = done_q;
    assign host.err       = err_q;
    assign cnt_enable_o   = enable_q;
    assign cnt_mode_o     = mode_q;
    assign en_preset_o    = preset_q;
    assign init_sec_o     = sec_q;
    assign init_min_o     = min_q;
    assign init_hour_o    = hour_q;
    assign init_mode_o    = imode_q;
    assign init_dow_o     = dow_q;
    assign init_dom_o     = dom_q;
    assign init_month_o   = month_q;
    assign init_year_o    = year_q;
endmodule

// File: tb/tb_rtc_preset_ctrl.sv
// Bench for rtc_preset_ctrl: directed scenarios plus randomized commands
// checked against a transaction-level model of the command timeline.
module tb_rtc_preset_ctrl;
    localparam int MIN_YEAR = 2000;
    localparam int MAX_YEAR = 2099;
    localparam logic [1:0] C_NOP = 2'b00, C_START = 2'b01, C_STOP = 2'b10, C_SET = 2'b11;

    typedef struct {
        int sec; int min; int hour; int mode; int dow; int dom; int month; int year;
    } pl_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rtc_preset_ctrl_if bus();
    logic        cnt_enable, cnt_mode, en_preset;
    logic [5:0]  init_sec, init_min;
    logic [4:0]  init_hour, init_dom;
    logic [1:0]  init_mode;
    logic [2:0]  init_dow;
    logic [3:0]  init_month;
    logic [11:0] init_year;

    rtc_preset_ctrl #(.MIN_YEAR(MIN_YEAR), .MAX_YEAR(MAX_YEAR)) dut (
        .clk_1Hz_i(clk), .rstn_i(rstn), .host(bus),
        .cnt_enable_o(cnt_enable), .cnt_mode_o(cnt_mode), .en_preset_o(en_preset),
        .init_sec_o(init_sec), .init_min_o(init_min), .init_hour_o(init_hour),
        .init_mode_o(init_mode), .init_dow_o(init_dow), .init_dom_o(init_dom),
        .init_month_o(init_month), .init_year_o(init_year)
    );

    int  checks = 0;
    int  errors = 0;
    bit  m_en;
    bit  m_mode;
    pl_t m_init;
    pl_t defaults = '{0, 0, 0, 0, 1, 1, 1, 2000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference rule set written from the calendar definition.
    function automatic bit ref_valid(input pl_t p);
        int  days[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        bit  leap;
        int  md;
        if (p.sec > 59 || p.min > 59) return 0;
        if (p.mode == 2) return 0;
        if ((p.mode % 2) == 1) begin
            if (p.hour < 1 || p.hour > 12) return 0;
        end else if (p.hour > 23) return 0;
        if (p.dow < 1 || p.dow > 7) return 0;
        if (p.month < 1 || p.month > 12) return 0;
        if (p.year < MIN_YEAR || p.year > MAX_YEAR) return 0;
        leap = ((p.year % 4 == 0) && (p.year % 100 != 0)) || (p.year % 400 == 0);
        md = days[p.month];
        if (p.month == 2 && leap) md = 29;
        return (p.dom >= 1 && p.dom <= md);
    endfunction

    task automatic check_all(input string tag, input logic rdy, input logic pre,
                             input logic don, input logic er);
        chk({tag, ".ready"}, bus.cmd_ready, rdy);
        chk({tag, ".preset"}, en_preset, pre);
        chk({tag, ".done"}, bus.done, don);
        chk({tag, ".err"}, bus.err, er);
        chk({tag, ".enable"}, cnt_enable, m_en);
        chk({tag, ".mode"}, cnt_mode, m_mode);
        chk({tag, ".init_sec"}, init_sec, m_init.sec);
        chk({tag, ".init_min"}, init_min, m_init.min);
        chk({tag, ".init_hour"}, init_hour, m_init.hour);
        chk({tag, ".init_mode"}, init_mode, m_init.mode);
        chk({tag, ".init_dow"}, init_dow, m_init.dow);
        chk({tag, ".init_dom"}, init_dom, m_init.dom);
        chk({tag, ".init_month"}, init_month, m_init.month);
        chk({tag, ".init_year"}, init_year, m_init.year);
    endtask

    task automatic drive(input logic [1:0] c, input pl_t p);
        bus.cmd       = c;
        bus.set_sec   = 6'(p.sec);
        bus.set_min   = 6'(p.min);
        bus.set_hour  = 5'(p.hour);
        bus.set_mode  = 2'(p.mode);
        bus.set_dow   = 3'(p.dow);
        bus.set_dom   = 5'(p.dom);
        bus.set_month = 4'(p.month);
        bus.set_year  = 12'(p.year);
    endtask

    // Present a command and return just after the edge that accepts it.
    task automatic send(input logic [1:0] c, input pl_t p, input bit keep);
        int n = 0;
        drive(c, p);
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    // Walk the expected output timeline that follows an accepted command.
    task automatic expect_cmd(input string tag, input logic [1:0] c, input pl_t p);
        case (c)
            C_NOP: begin
                @(negedge clk); check_all({tag, ".nop"}, 1, 0, 0, 0);
            end
            C_START, C_STOP: begin
                if (c == C_START) begin
                    m_en = 1; m_mode = (p.mode % 2) == 1;
                end else m_en = 0;
                @(negedge clk); check_all({tag, ".c1"}, 0, 0, 1, 0);
                @(negedge clk); check_all({tag, ".c2"}, 1, 0, 0, 0);
            end
            default: begin
                if (ref_valid(p)) begin
                    m_en = 1; m_mode = (p.mode % 2) == 1; m_init = p;
                    @(negedge clk); check_all({tag, ".s1"}, 0, 1, 0, 0);
                    @(negedge clk); check_all({tag, ".s2"}, 0, 0, 0, 0);
                    @(negedge clk); check_all({tag, ".s3"}, 0, 0, 1, 0);
                    @(negedge clk); check_all({tag, ".s4"}, 1, 0, 0, 0);
                end else begin
                    @(negedge clk); check_all({tag, ".e1"}, 1, 0, 0, 1);
                    @(negedge clk); check_all({tag, ".e2"}, 1, 0, 0, 0);
                end
            end
        endcase
    endtask

    function automatic pl_t rand_pl();
        pl_t p;
        int  hs[6] = '{0, 1, 12, 13, 23, 24};
        int  ds[5] = '{0, 28, 29, 30, 31};
        int  ys[6] = '{1999, 2000, 2099, 2100, 2023, 2024};
        int  k = $urandom_range(0, 2);
        if (k == 0) begin
            p = '{$urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 31),
                  $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 31),
                  $urandom_range(0, 15), $urandom_range(0, 4095)};
        end else if (k == 1) begin
            p.mode = $urandom_range(0, 1);
            p = '{$urandom_range(0, 59), $urandom_range(0, 59),
                  (p.mode == 1) ? $urandom_range(1, 12) : $urandom_range(0, 23),
                  p.mode, $urandom_range(1, 7), $urandom_range(1, 31),
                  $urandom_range(1, 12), $urandom_range(2000, 2099)};
        end else begin
            p = '{($urandom_range(0, 1) == 1) ? 59 : 60, $urandom_range(0, 60),
                  hs[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 7),
                  ds[$urandom_range(0, 4)], $urandom_range(0, 13), ys[$urandom_range(0, 5)]};
        end
        return p;
    endfunction

    initial begin
        pl_t p, q;
        logic [1:0] c;
        bus.cmd_valid = 1'b0;
        drive(C_NOP, defaults);
        m_en = 0; m_mode = 0; m_init = defaults;

        // Reset state
        repeat (2) @(negedge clk);
        check_all("reset", 1, 0, 0, 0);
        rstn = 1'b1;
        @(negedge clk);
        check_all("post_reset", 1, 0, 0, 0);

        // SET from stopped state: enable and preset rise together
        p = '{58, 59, 23, 0, 7, 31, 12, 2023};
        send(C_SET, p, 0); expect_cmd("set_nye", C_SET, p);

        p = '{0, 0, 10, 0, 3, 29, 2, 2100};
        send(C_SET, p, 0); expect_cmd("feb29_2100", C_SET, p);
        p = '{0, 0, 10, 0, 4, 29, 2, 2024};
        send(C_SET, p, 0); expect_cmd("feb29_2024", C_SET, p);
        p = '{0, 0, 0, 1, 1, 1, 1, 2030};
        send(C_SET, p, 0); expect_cmd("h0_12h", C_SET, p);
        p = '{0, 0, 12, 1, 1, 1, 1, 2030};
        send(C_SET, p, 0); expect_cmd("h12_am", C_SET, p);
        p = '{0, 0, 5, 2, 1, 1, 1, 2030};
        send(C_SET, p, 0); expect_cmd("pm_24h", C_SET, p);

        // STOP, START, idle, STOP
        send(C_STOP, p, 0); expect_cmd("stop0", C_STOP, p);
        p.mode = 0;
        send(C_START, p, 0); expect_cmd("start", C_START, p);
        repeat (5) begin @(negedge clk); check_all("run", 1, 0, 0, 0); end
        send(C_STOP, p, 0); expect_cmd("stop", C_STOP, p);

        // Back-to-back SETs while running: second held until ready
        p = '{1, 2, 3, 0, 2, 15, 6, 2050};
        send(C_START, p, 0); expect_cmd("start2", C_START, p);
        p = '{10, 20, 8, 1, 5, 30, 4, 2060};
        q = '{33, 44, 11, 3, 6, 31, 7, 2061};
        send(C_SET, p, 1);
        drive(C_SET, q);
        expect_cmd("b2b_a", C_SET, p);
        send(C_SET, q, 0); expect_cmd("b2b_b", C_SET, q);

        // Reset during SETTLE drops the SET
        p = '{5, 6, 7, 0, 1, 9, 9, 2077};
        send(C_SET, p, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        m_en = 0; m_mode = 0; m_init = defaults;
        check_all("rst_settle", 1, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) begin @(negedge clk); check_all("after_rst", 1, 0, 0, 0); end

        // Randomized commands against the model
        for (int i = 0; i < 200; i++) begin
            int r = $urandom_range(0, 5);
            c = (r == 0) ? C_NOP : (r == 1) ? C_START : (r == 2) ? C_STOP : C_SET;
            p = rand_pl();
            send(c, p, 0);
            expect_cmd("rand", c, p);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); check_all("rand_gap", 1, 0, 0, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
